// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline memory stage.
//   RNONE       : bubble / reset value for registered outputs
//   state_e     : memory-access FSM encoding (IDLE=0, BUSY=1)
//   ADDR_W_DEF  : default data-memory word-address width
//   MEM_LAT_DEF : default memory-access latency in cycles
//   BYTE_OFS    : low address bits dropped to form the word index
package pipe_pkg;

    localparam logic [31:0] RNONE = 32'd0;

    localparam int ADDR_W_DEF  = 10;
    localparam int MEM_LAT_DEF = 2;
    localparam int BYTE_OFS    = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Data memory: 2^ADDR_W words of 32 bits.
//   Clk   : clock, write on rising edge
//   we    : write enable (asserted only on an access completion cycle)
//   addr  : word index
//   wdata : store data
//   rdata : combinational read of the addressed word (old value on a
//           same-cycle write, giving read-before-write)
module dmem_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // NOTE: the storage array has no reset; clearing a RAM needs a
    // per-word loop that cannot map onto a memory macro.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline.
//   Clk, Reset               : clock, synchronous active-high reset
//   MemWr/MemtoReg           : store / load request from EX/MEM
//   Branch/Zero/Target       : conditional branch resolution
//   Jump/jump_target         : unconditional jump
//   RegWr/ALUout/busB/Rw     : remaining EX/MEM payload
//   mem_stall                : holds upstream while an access is in flight
//   pc_redirect/flush/redirect_target : PC redirect and upstream flush
//   *_out                    : MEM/WB pipeline register
module mem_stage #(
    parameter int          ADDR_W  = pipe_pkg::ADDR_W_DEF,
    parameter int          MEM_LAT = pipe_pkg::MEM_LAT_DEF,
    parameter logic [31:0] RNONE   = pipe_pkg::RNONE
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemWr,
    input  logic        Branch,
    input  logic        MemtoReg,
    input  logic        RegWr,
    input  logic [31:0] Target,
    input  logic        Zero,
    input  logic [31:0] ALUout,
    input  logic [31:0] busB,
    input  logic [4:0]  Rw,
    input  logic        Jump,
    input  logic [31:0] jump_target,
    output logic        mem_stall,
    output logic        pc_redirect,
    output logic [31:0] redirect_target,
    output logic        flush,
    output logic        MemtoReg_out,
    output logic        RegWr_out,
    output logic [31:0] ALUout_out,
    output logic [31:0] Dout_out,
    output logic [4:0]  Rw_out
);

    import pipe_pkg::*;

    localparam int            CW   = $clog2(MEM_LAT) + 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          mop;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    assign mop = MemWr | MemtoReg;

    // NOTE: every output of this block gets a default before the case so
    // no path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mem_stall = 1'b0;
        unique case (state)
            IDLE: begin
                if (mop && (MEM_LAT > 1)) begin
                    mem_stall = 1'b1;
                    state_n   = BUSY;
                    cnt_n     = CW'(1);
                end
            end
            BUSY: begin
                if (cnt < LAST) begin
                    mem_stall = 1'b1;
                    cnt_n     = cnt + CW'(1);
                end else begin
                    // Completion cycle of a multi-cycle access.
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Reset aborts an in-flight store so memory is left untouched.
    assign ram_we = MemWr & ~mem_stall & ~Reset;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_dmem_ram (
        .Clk   (Clk),
        .we    (ram_we),
        .addr  (ALUout[ADDR_W+BYTE_OFS-1:BYTE_OFS]),
        .wdata (busB),
        .rdata (ram_rdata)
    );

    // A redirect is only taken once the instruction is no longer stalled;
    // the flush then bubbles EX/MEM, so the pulse cannot repeat.
    assign pc_redirect     = (Jump | (Branch & Zero)) & ~mem_stall;
    assign redirect_target = Jump ? jump_target : Target;
    assign flush           = pc_redirect;

    always_ff @(posedge Clk) begin
        if (Reset || mem_stall) begin
            MemtoReg_out <= RNONE[0];
            RegWr_out    <= RNONE[0];
            ALUout_out   <= RNONE;
            Dout_out     <= RNONE;
            Rw_out       <= RNONE[4:0];
        end else begin
            MemtoReg_out <= MemtoReg;
            RegWr_out    <= RegWr;
            ALUout_out   <= ALUout;
            Dout_out     <= MemtoReg ? ram_rdata : RNONE;
            Rw_out       <= Rw;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage. Instance u_a uses MEM_LAT=2,
// instance u_b uses MEM_LAT=3; both use ADDR_W=10.
module tb_mem_stage;

    typedef struct packed {
        logic        mem_wr;
        logic        branch;
        logic        mem_to_reg;
        logic        reg_wr;
        logic        zero;
        logic        jump;
        logic [31:0] target;
        logic [31:0] alu_out;
        logic [31:0] bus_b;
        logic [31:0] jump_target;
        logic [4:0]  rw;
    } in_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic rst_a, rst_b;
    in_t  in_a, in_b;

    logic        st_a, pr_a, fl_a, m2r_a, rwr_a;
    logic [31:0] rt_a, alu_a, dout_a;
    logic [4:0]  rw_a;
    logic        st_b, pr_b, fl_b, m2r_b, rwr_b;
    logic [31:0] rt_b, alu_b, dout_b;
    logic [4:0]  rw_b;

    int checks = 0;
    int errors = 0;

    mem_stage #(.ADDR_W(10), .MEM_LAT(2)) u_a (
        .Clk(Clk), .Reset(rst_a),
        .MemWr(in_a.mem_wr), .Branch(in_a.branch), .MemtoReg(in_a.mem_to_reg),
        .RegWr(in_a.reg_wr), .Target(in_a.target), .Zero(in_a.zero),
        .ALUout(in_a.alu_out), .busB(in_a.bus_b), .Rw(in_a.rw),
        .Jump(in_a.jump), .jump_target(in_a.jump_target),
        .mem_stall(st_a), .pc_redirect(pr_a), .redirect_target(rt_a),
        .flush(fl_a), .MemtoReg_out(m2r_a), .RegWr_out(rwr_a),
        .ALUout_out(alu_a), .Dout_out(dout_a), .Rw_out(rw_a)
    );

    mem_stage #(.ADDR_W(10), .MEM_LAT(3)) u_b (
        .Clk(Clk), .Reset(rst_b),
        .MemWr(in_b.mem_wr), .Branch(in_b.branch), .MemtoReg(in_b.mem_to_reg),
        .RegWr(in_b.reg_wr), .Target(in_b.target), .Zero(in_b.zero),
        .ALUout(in_b.alu_out), .busB(in_b.bus_b), .Rw(in_b.rw),
        .Jump(in_b.jump), .jump_target(in_b.jump_target),
        .mem_stall(st_b), .pc_redirect(pr_b), .redirect_target(rt_b),
        .flush(fl_b), .MemtoReg_out(m2r_b), .RegWr_out(rwr_b),
        .ALUout_out(alu_b), .Dout_out(dout_b), .Rw_out(rw_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Run one access on u_b: count stall cycles (bounded), then clock the
    // completion edge and return to idle inputs.
    task automatic run_op_b(input string tag, input in_t v, input int exp_stalls);
        int n;
        in_b = v;
        #1;
        n = 0;
        while (st_b === 1'b1 && n < 8) begin
            n++;
            tick();
        end
        check({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
        tick();
        in_b = '0;
        #1;
    endtask

    in_t v;

    initial begin
        in_a  = '0;
        in_b  = '0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;

        // Reset state
        check("rst_stall",  32'(st_a),  32'd0);
        check("rst_regwr",  32'(rwr_a), 32'd0);
        check("rst_alu",    alu_a,      32'd0);
        check("rst_dout",   dout_a,     32'd0);
        check("rst_rw",     32'(rw_a),  32'd0);

        // MEM_LAT=2 store 0xDEADBEEF to 0x10
        in_a = '0;
        in_a.mem_wr  = 1'b1;
        in_a.alu_out = 32'h10;
        in_a.bus_b   = 32'hDEADBEEF;
        #1;
        check("st_stall0",  32'(st_a),  32'd1);
        tick();
        check("st_bubble",  32'(rwr_a), 32'd0);
        check("st_stall1",  32'(st_a),  32'd0);
        tick();

        // MEM_LAT=2 load from 0x10
        in_a = '0;
        in_a.mem_to_reg = 1'b1;
        in_a.reg_wr     = 1'b1;
        in_a.alu_out    = 32'h10;
        in_a.rw         = 5'd5;
        #1;
        check("ld_stall0",  32'(st_a),  32'd1);
        tick();
        check("ld_bubble",  32'(rwr_a), 32'd0);
        check("ld_stall1",  32'(st_a),  32'd0);
        tick();
        check("ld_dout",    dout_a,     32'hDEADBEEF);
        check("ld_rw",      32'(rw_a),  32'd5);
        check("ld_regwr",   32'(rwr_a), 32'd1);
        check("ld_m2r",     32'(m2r_a), 32'd1);

        // ALU op, no memory access
        in_a = '0;
        in_a.reg_wr  = 1'b1;
        in_a.alu_out = 32'h1234;
        in_a.rw      = 5'd3;
        #1;
        check("alu_stall",  32'(st_a),  32'd0);
        tick();
        check("alu_out",    alu_a,      32'h1234);
        check("alu_rw",     32'(rw_a),  32'd3);
        check("alu_dout",   dout_a,     32'd0);

        // Taken branch
        in_a = '0;
        in_a.branch = 1'b1;
        in_a.zero   = 1'b1;
        in_a.target = 32'h40;
        #1;
        check("br_redir",   32'(pr_a),  32'd1);
        check("br_flush",   32'(fl_a),  32'd1);
        check("br_target",  rt_a,       32'h40);
        in_a.zero = 1'b0;
        #1;
        check("br_nt_redir", 32'(pr_a), 32'd0);
        check("br_nt_flush", 32'(fl_a), 32'd0);

        // Jump has priority over a taken branch
        in_a.zero        = 1'b1;
        in_a.jump        = 1'b1;
        in_a.jump_target = 32'h100;
        #1;
        check("jmp_redir",  32'(pr_a),  32'd1);
        check("jmp_target", rt_a,       32'h100);

        // Redirect suppressed while stalled, taken on completion cycle
        in_a = '0;
        in_a.branch     = 1'b1;
        in_a.zero       = 1'b1;
        in_a.target     = 32'h80;
        in_a.mem_to_reg = 1'b1;
        in_a.alu_out    = 32'h10;
        #1;
        check("brst_redir0", 32'(pr_a), 32'd0);
        tick();
        check("brst_redir1", 32'(pr_a), 32'd1);
        tick();
        in_a = '0;

        // MEM_LAT=3: seed 0x20 with 0, then reset during a store of 0xA5A5A5A5
        v = '0;
        v.mem_wr  = 1'b1;
        v.alu_out = 32'h20;
        v.bus_b   = 32'h0;
        run_op_b("seed", v, 2);

        in_b = '0;
        in_b.mem_wr  = 1'b1;
        in_b.alu_out = 32'h20;
        in_b.bus_b   = 32'hA5A5A5A5;
        #1;
        check("ab_stall0",  32'(st_b),  32'd1);
        tick();
        check("ab_stall1",  32'(st_b),  32'd1);
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        in_b  = '0;
        #1;
        check("ab_stall",   32'(st_b),  32'd0);
        check("ab_regwr",   32'(rwr_b), 32'd0);
        check("ab_m2r",     32'(m2r_b), 32'd0);
        check("ab_alu",     alu_b,      32'd0);
        check("ab_dout",    dout_b,     32'd0);
        check("ab_rw",      32'(rw_b),  32'd0);

        v = '0;
        v.mem_to_reg = 1'b1;
        v.reg_wr     = 1'b1;
        v.alu_out    = 32'h20;
        v.rw         = 5'd9;
        run_op_b("ab_ld", v, 2);
        check("ab_ld_dout", dout_b,     32'd0);
        check("ab_ld_rw",   32'(rw_b),  32'd9);

        // Address wrap: 0x1000 aliases word 0 when ADDR_W=10
        v = '0;
        v.mem_wr  = 1'b1;
        v.alu_out = 32'h0;
        v.bus_b   = 32'h77;
        run_op_b("wr_st", v, 2);
        v = '0;
        v.mem_to_reg = 1'b1;
        v.reg_wr     = 1'b1;
        v.alu_out    = 32'h1000;
        v.rw         = 5'd7;
        run_op_b("wr_ld", v, 2);
        check("wrap_dout",  dout_b,     32'h77);
        check("wrap_alu",   alu_b,      32'h1000);
        check("wrap_regwr", 32'(rwr_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory stage of the 5-stage pipeline. It sits directly downstream of the EX/MEM register and consumes everything that register produces.
- Performs data-memory loads and stores with a parameterised multi-cycle latency, asserting a stall while an access is in flight.
- Resolves branch/jump redirects and drives the flush to the earlier stages.
- Contains the MEM/WB pipeline register feeding write-back.

Parameters:
ADDR_W, 10, word-address bits of the internal data memory (depth 2^ADDR_W words of 32 bits)
MEM_LAT, 2, cycles a load/store occupies the stage (>=1); MEM_LAT=1 means no stall
RNONE, 0, bubble/reset value for all registered outputs

Ports:
Clk  in  1  clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
MemWr  in  1  store request (from EX/MEM)
Branch  in  1  conditional branch instruction
MemtoReg  in  1  load request; WB selects memory data
RegWr  in  1  instruction writes register file
Target  in  32  branch target address
Zero  in  1  ALU zero flag
ALUout  in  32  ALU result / byte address for memory ops
busB  in  32  store data
Rw  in  5  destination register
Jump  in  1  unconditional jump
jump_target  in  32  jump address
mem_stall  out  1  combinational; holds PC, IF/ID, ID/EX, EX/MEM
pc_redirect  out  1  combinational; load redirect_target into PC
redirect_target  out  32  combinational redirect address
flush  out  1  combinational; bubble IF/ID, ID/EX, EX/MEM
MemtoReg_out  out  1  MEM/WB register
RegWr_out  out  1  MEM/WB register
ALUout_out  out  32  MEM/WB register
Dout_out  out  32  MEM/WB register, load data
Rw_out  out  5  MEM/WB register

Behaviour:
- Reset (synchronous, highest priority):
  - FSM returns to IDLE and the counter clears to 0.
  - All MEM/WB outputs go to RNONE.
  - Any in-flight store is aborted and memory is not written.
  - RAM contents are not cleared.
- Memory op: mop = MemWr | MemtoReg.
- Address: word index = ALUout[ADDR_W+1:2]. Low two bits are ignored and upper bits are dropped, so the address wraps modulo depth.
- FSM states IDLE and BUSY, with counter cnt of width clog2(MEM_LAT)+1.
- IDLE:
  - mop=1 and MEM_LAT>1: mem_stall=1; next state BUSY, cnt=1.
  - Otherwise mem_stall=0 and the op completes this cycle.
- BUSY:
  - cnt<MEM_LAT-1: mem_stall=1, cnt++.
  - cnt==MEM_LAT-1: mem_stall=0, the op completes this cycle, next state IDLE, cnt=0.
- Completion cycle (mem_stall=0):
  - Store: memory word is written on that edge.
  - Load: Dout_out captures the word.
  - MemWr and MemtoReg both set: read-before-write, so Dout_out gets the old word.
  - Non-load: Dout_out gets RNONE.
- MEM/WB register, on each non-reset edge:
  - mem_stall=1: all outputs get RNONE (bubble; RegWr_out=0).
  - Otherwise outputs load MemtoReg, RegWr, ALUout, the memory read data, and Rw.
- Inputs are stable during a stall because upstream is held by mem_stall; the block does not re-latch them.
- Redirect: pc_redirect = (Jump | (Branch & Zero)) & ~mem_stall.
  - redirect_target = jump_target if Jump, else Target; Jump has priority when both are set.
  - flush = pc_redirect.
  - The branch/jump instruction still passes into MEM/WB normally.
- Redirect/flush are single-cycle pulses. The flush bubbles EX/MEM on the same edge, so no repeat pulse occurs.
- Latency: non-memory op appears at MEM/WB after 1 edge; memory op after MEM_LAT edges.

Decomposition:
- Shared package pipe_pkg holds:
  - RNONE
  - FSM state encoding (IDLE=0, BUSY=1)
  - default ADDR_W / MEM_LAT
  - word-index slice helper constant (byte offset 2)
- One natural sub-module, dmem_ram: 2^ADDR_W x 32, combinational read, synchronous write enabled only on the completion cycle. The FSM, redirect logic and MEM/WB register stay in mem_stage.

Test Plan:
- MEM_LAT=2; store MemWr=1, ALUout=0x10, busB=0xDEADBEEF, then load MemtoReg=1, RegWr=1, ALUout=0x10, Rw=5:
  - Each op gives mem_stall=1 for exactly 1 cycle with RegWr_out=0 that cycle.
  - After the load completes: Dout_out=0xDEADBEEF, Rw_out=5, RegWr_out=1.
- ALU op RegWr=1, ALUout=0x1234, Rw=3, no mop -> mem_stall never asserts; next edge ALUout_out=0x1234, Rw_out=3, Dout_out=0.
- Branch=1, Zero=1, Target=0x40 -> same cycle pc_redirect=1, flush=1, redirect_target=0x40. With Zero=0 -> pc_redirect=0.
- Jump=1, Branch=1, Zero=1, jump_target=0x100, Target=0x40 -> redirect_target=0x100.
- Reset mid-access, MEM_LAT=3: store to 0x20 of 0xA5A5A5A5, Reset asserted on the 2nd stall cycle -> mem_stall=0 after the edge, all outputs 0; a later load of 0x20 returns the prior value (0).
- MEM_LAT=3, ADDR_W=10: load from ALUout=0x1000 after storing 0x77 at ALUout=0x0 -> 2 stall cycles, then Dout_out=0x77 (address wrap).
